// File: rtl/traffic_pkg.sv
// Shared state codes, lamp encodings and approach identifiers for the
// intersection scheduler.
package traffic_pkg;

  typedef enum logic [3:0] {
    ST_STARTUP   = 4'd0,
    ST_CLEAR     = 4'd1,
    ST_NS_RY     = 4'd2,
    ST_NS_GREEN  = 4'd3,
    ST_NS_YELLOW = 4'd4,
    ST_EW_RY     = 4'd5,
    ST_EW_GREEN  = 4'd6,
    ST_EW_YELLOW = 4'd7,
    ST_PED_WALK  = 4'd8
  } state_t;

  typedef enum logic {
    NS = 1'b0,
    EW = 1'b1
  } approach_t;

  // Lamp vectors are {red, yellow, green}.
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_RY  = 3'b110;

  // Lamp shown to approach 'a' in any state other than STARTUP.
  function automatic logic [2:0] lamp_for(state_t s, approach_t a);
    logic [2:0] l;
    l = LAMP_RED;
    unique case (s)
      ST_NS_RY:     if (a == NS) l = LAMP_RY;
      ST_NS_GREEN:  if (a == NS) l = LAMP_GRN;
      ST_NS_YELLOW: if (a == NS) l = LAMP_YEL;
      ST_EW_RY:     if (a == EW) l = LAMP_RY;
      ST_EW_GREEN:  if (a == EW) l = LAMP_GRN;
      ST_EW_YELLOW: if (a == EW) l = LAMP_YEL;
      default:      l = LAMP_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: counts tick enables within the current state, clears on a
// state change, optionally saturates, and flags the tick on which the
// current state's duration elapses.
module phase_timer #(
  parameter int unsigned TW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          tick_i,
  input  logic          sat_i,
  input  logic [TW-1:0] sat_val_i,
  input  logic [TW:0]   dur_i,
  output logic [TW-1:0] count_o,
  output logic          expire_o
);

  logic [TW-1:0] count_q, count_d;

  // Next count: clear wins, otherwise advance on tick (holding at the
  // saturation value when requested).
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i) begin
      if (sat_i && (count_q >= sat_val_i)) count_d = sat_val_i;
      else                                 count_d = count_q + TW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o  = count_q;
  // A state of duration T ends on the tick seen while count == T-1.
  assign expire_o = tick_i && ({1'b0, count_q} == (dur_i - (TW+1)'(1)));

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach intersection controller with one pedestrian crossing.
// Sequences NS/EW through red+yellow, green, yellow and all-red clearance,
// chooses the next approach and arbitrates the pedestrian walk phase.
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned TW        = 6,
  parameter int unsigned STARTUP_T = 4,
  parameter int unsigned MIN_GREEN = 8,
  parameter int unsigned MAX_GREEN = 30,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned RY_T      = 2,
  parameter int unsigned CLEAR_T   = 2,
  parameter int unsigned WALK_T    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       req_ns,
  input  logic       req_ew,
  input  logic       ped_req,
  output logic [2:0] ns_lamps,
  output logic [2:0] ew_lamps,
  output logic       ped_walk,
  output logic       ped_pending,
  output logic [3:0] phase
);

  localparam logic [TW:0]   DUR_STARTUP = (TW+1)'(STARTUP_T);
  localparam logic [TW:0]   DUR_YELLOW  = (TW+1)'(YELLOW_T);
  localparam logic [TW:0]   DUR_RY      = (TW+1)'(RY_T);
  localparam logic [TW:0]   DUR_CLEAR   = (TW+1)'(CLEAR_T);
  localparam logic [TW:0]   DUR_WALK    = (TW+1)'(WALK_T);
  localparam logic [TW:0]   DUR_MING    = (TW+1)'(MIN_GREEN);
  localparam logic [TW-1:0] MIN_M1      = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_M1      = TW'(MAX_GREEN - 1);

  state_t    state_q, state_d, clear_next;
  approach_t last_q, last_d;
  logic      after_walk_q, after_walk_d;
  logic      flash_q, flash_d;
  logic      ped_pending_q, ped_pending_d;
  logic      ped_prev_q;

  logic [TW:0]   dur;
  logic [TW-1:0] count;
  logic          expire;
  logic          in_green, own_req, oth_req, green_done;
  logic          ped_rise, ped_block;

  assign in_green = (state_q == ST_NS_GREEN) || (state_q == ST_EW_GREEN);
  assign own_req  = (state_q == ST_EW_GREEN) ? req_ew : req_ns;
  assign oth_req  = (state_q == ST_EW_GREEN) ? req_ns : req_ew;

  // Green ends only when something else is waiting and the minimum has run;
  // continuing own demand extends it up to the maximum.
  assign green_done = tick && (oth_req || ped_pending_q) && (count >= MIN_M1) &&
                      (!own_req || (count >= MAX_M1));

  // Duration of the current state for the timer's expiry compare.
  always_comb begin
    dur = DUR_MING;
    unique case (state_q)
      ST_STARTUP:                  dur = DUR_STARTUP;
      ST_CLEAR:                    dur = DUR_CLEAR;
      ST_NS_RY, ST_EW_RY:          dur = DUR_RY;
      ST_NS_YELLOW, ST_EW_YELLOW:  dur = DUR_YELLOW;
      ST_PED_WALK:                 dur = DUR_WALK;
      default:                     dur = DUR_MING;
    endcase
  end

  phase_timer #(.TW(TW)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_d != state_q),
    .tick_i    (tick),
    .sat_i     (in_green),
    .sat_val_i (MAX_M1),
    .dur_i     (dur),
    .count_o   (count),
    .expire_o  (expire)
  );

  // Approach served after an all-red clearance, in priority order.
  always_comb begin
    if (ped_pending_q && !after_walk_q)  clear_next = ST_PED_WALK;
    else if (last_q == NS && req_ew)     clear_next = ST_EW_RY;
    else if (last_q == EW)               clear_next = ST_NS_RY;
    else if (req_ns || !req_ew)          clear_next = ST_NS_RY;
    else                                 clear_next = ST_EW_RY;
  end

  // Next state and last-served approach.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ST_STARTUP:   if (expire) state_d = ST_CLEAR;
      ST_CLEAR:     if (expire) state_d = clear_next;
      ST_NS_RY:     if (expire) state_d = ST_NS_GREEN;
      ST_EW_RY:     if (expire) state_d = ST_EW_GREEN;
      ST_NS_GREEN:  if (green_done) state_d = ST_NS_YELLOW;
      ST_EW_GREEN:  if (green_done) state_d = ST_EW_YELLOW;
      ST_NS_YELLOW: if (expire) begin state_d = ST_CLEAR; last_d = NS; end
      ST_EW_YELLOW: if (expire) begin state_d = ST_CLEAR; last_d = EW; end
      ST_PED_WALK:  if (expire) state_d = ST_CLEAR;
      default:      state_d = ST_STARTUP;
    endcase
  end

  assign ped_rise  = ped_req && !ped_prev_q;
  assign ped_block = (state_q == ST_STARTUP) || (state_q == ST_PED_WALK) ||
                     ((state_q == ST_CLEAR) && after_walk_q);

  // Pedestrian latch, post-walk marker and startup flasher.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if (state_d == ST_PED_WALK && state_q != ST_PED_WALK) ped_pending_d = 1'b0;
    else if (ped_rise && !ped_block)                       ped_pending_d = 1'b1;

    after_walk_d = after_walk_q;
    if (state_q == ST_PED_WALK && state_d == ST_CLEAR)     after_walk_d = 1'b1;
    else if (state_q == ST_CLEAR && state_d != ST_CLEAR)   after_walk_d = 1'b0;

    flash_d = 1'b1;
    if (state_q == ST_STARTUP && state_d == ST_STARTUP)    flash_d = flash_q ^ tick;
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_STARTUP;
      last_q        <= EW;
      after_walk_q  <= 1'b0;
      flash_q       <= 1'b1;
      ped_pending_q <= 1'b0;
      ped_prev_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      after_walk_q  <= after_walk_d;
      flash_q       <= flash_d;
      ped_pending_q <= ped_pending_d;
      ped_prev_q    <= ped_req;
    end
  end

  // Lamp and status decode straight from the state register.
  always_comb begin
    if (state_q == ST_STARTUP) begin
      ns_lamps = {1'b0, flash_q, 1'b0};
      ew_lamps = {1'b0, flash_q, 1'b0};
    end else begin
      ns_lamps = lamp_for(state_q, NS);
      ew_lamps = lamp_for(state_q, EW);
    end
    ped_walk    = (state_q == ST_PED_WALK);
    ped_pending = ped_pending_q;
    phase       = state_q;
  end

endmodule

// File: doc/intersection_scheduler.md
Name: intersection_scheduler

Overview:
Cycle-level controller for a two-approach intersection: north-south (NS, main road) and east-west (EW, side road), plus one pedestrian crossing. It decides which approach is served next and sequences each approach through red+yellow, green, yellow and all-red clearance. It also arbitrates the pedestrian walk phase against vehicle demand. All timing is counted in `tick` enables from the system prescaler, and its lamp outputs drive the signal-head drivers directly.

Parameters:
- TW, 6, width of the internal phase timer.
- STARTUP_T, 4, ticks of blinking yellow after reset.
- MIN_GREEN, 8, minimum green ticks.
- MAX_GREEN, 30, maximum green ticks while a conflicting demand is waiting.
- YELLOW_T, 3, yellow ticks.
- RY_T, 2, red+yellow ticks.
- CLEAR_T, 2, all-red clearance ticks.
- WALK_T, 10, pedestrian walk ticks.
- Legality: all timing parameters are >=1 and <=2^TW, and MIN_GREEN <= MAX_GREEN.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous, active-high.
- tick, in, 1, single-cycle timing enable.
- req_ns, in, 1, NS vehicle detector (level).
- req_ew, in, 1, EW vehicle detector (level).
- ped_req, in, 1, pedestrian button (synchronous, debounced level).
- ns_lamps, out, 3, {red, yellow, green}.
- ew_lamps, out, 3, {red, yellow, green}.
- ped_walk, out, 1, walk indication.
- ped_pending, out, 1, pedestrian request latched.
- phase, out, 4, current state code.

Behaviour:
- Reset:
  - state = STARTUP, timer = 0, flash = 1, ped_pending = 0, last_served = EW, after_walk = 0.
  - Resulting outputs: ns_lamps = ew_lamps = 3'b010, ped_walk = 0.
- Clock: already decided, reset is synchronous, active-high; clock is clk.
- Outputs are a combinational decode of the state register: no extra latency, and the lamps change on the same edge as the state.
- Timer:
  - Clears on every state change; otherwise increments on tick.
  - A state of duration T transitions on the tick where timer == T-1, so it lasts exactly T ticks.
  - Without tick, nothing advances.
- Lamp decode per state:
  - STARTUP: both yellow = flash. flash toggles on every tick and is held at 1 in all other states.
  - CLEAR and PED_WALK: both lamps 100.
  - NS_RY: ns_lamps 110, ew_lamps 100.
  - NS_GREEN: ns_lamps 001, ew_lamps 100.
  - NS_YELLOW: ns_lamps 010, ew_lamps 100.
  - EW_* states: mirrored (EW lamp follows the phase, NS lamp 100).
  - ped_walk = 1 only in PED_WALK.
- State transitions:
  - STARTUP --STARTUP_T--> CLEAR.
  - X_RY --RY_T--> X_GREEN.
  - X_YELLOW --YELLOW_T--> CLEAR; last_served <= X.
- Green termination (X_GREEN), evaluated on tick:
  - Define conflict = (other approach's request) | ped_pending.
  - Go to X_YELLOW when conflict AND timer >= MIN_GREEN-1 AND (own request == 0 OR timer >= MAX_GREEN-1).
  - With no conflict, green rests indefinitely; the timer saturates at MAX_GREEN-1.
- CLEAR --CLEAR_T--> next approach, chosen in priority order:
  1. PED_WALK, if ped_pending and !after_walk.
  2. EW_RY, if last_served == NS and req_ew.
  3. NS_RY, if last_served == EW.
  4. Otherwise NS_RY if req_ns or !req_ew, else EW_RY.
- PED_WALK --WALK_T--> CLEAR, with after_walk <= 1. after_walk clears on leaving CLEAR.
- Pedestrian latch:
  - ped_pending sets on a rising edge of ped_req, sampled every clk regardless of tick.
  - It clears on the edge entering PED_WALK; a clear on that edge wins over a simultaneous set.
  - Rising edges are ignored in PED_WALK and in the CLEAR that follows it.
  - ped_pending is never set in STARTUP.
- Conflict-free invariant: at no time may ns_lamps and ew_lamps both have green or yellow set outside STARTUP. The verification engineer asserts this.
- Reset mid-operation: reset returns to the reset values on the next edge, from any state.

Decomposition:
- Shared package (traffic_pkg): 4-bit state codes, lamp encodings (LAMP_RED = 3'b100, LAMP_YEL = 3'b010, LAMP_GRN = 3'b001, LAMP_RY = 3'b110) and the approach enum (NS = 0, EW = 1).
- One sub-module is natural: phase_timer. It holds the TW-bit counter with clear, tick-enable and saturate inputs, plus an expiry compare against a muxed duration.
- The FSM, next-approach selection and pedestrian latch stay in intersection_scheduler.

Test Plan:
1. Reset, tick every cycle, no requests -> ns_lamps 010,000,010,000 over 4 ticks; then both 100 for 2 ticks; ns 110 for 2 ticks; then ns 001 held indefinitely, ew 100.
2. req_ew = 1 from reset, req_ns = 0 -> NS_GREEN lasts exactly 8 ticks, NS_YELLOW 3, CLEAR 2, EW_RY 2; then EW_GREEN rests.
3. req_ns = req_ew = 1 held -> NS_GREEN lasts 30 ticks, then yellow; EW then also lasts 30 ticks; service alternates.
4. ped_req pulse at tick 3 of NS_GREEN, no vehicles -> ped_pending = 1; green ends at 8 ticks; yellow 3, clear 2; PED_WALK 10 ticks with ped_walk = 1, all lamps 100, and ped_pending clearing on the entry edge; then CLEAR 2, then NS_RY.
5. ped_req pulses during PED_WALK and the following CLEAR -> ignored, ped_pending stays 0, no second walk.
6. tick held low for 50 cycles mid-green -> state, timer and lamps frozen; a ped_req edge is still latched. Reset asserted in EW_GREEN -> next cycle phase = STARTUP, lamps 010/010, ped_pending = 0.
